// File: rtl/spi_master_param.sv
// SPI master with configurable width, SCLK divider and chip-select count, plus runtime CPOL/CPHA.
// Define SPI_LOOPBACK_EN to feed MOSI back into the receive path in place of MISO.
module spi_master_param #(
  parameter int DW        = 11,
  parameter int HALF_DIV  = 25,
  parameter int NCS       = 2,
  parameter int MSB_FIRST = 1,
  localparam int CSW      = (NCS > 1) ? $clog2(NCS) : 1,
  localparam int DIVW     = $clog2(HALF_DIV)
) (
  input  logic           clk,
  input  logic           clr,
  input  logic           st,
  input  logic [CSW-1:0] cs_sel,
  input  logic           cpol,
  input  logic           cpha,
  input  logic [DW-1:0]  tx_dat,
  input  logic           MISO,
  output logic           MOSI,
  output logic           SCLK,
  output logic [NCS-1:0] SS_n,
  output logic [DW-1:0]  rx_dat,
  output logic           busy,
  output logic           end_TX,
  output logic [7:0]     cb_bit
);
  typedef enum logic [1:0] {IDLE, ACTIVE, GUARD} state_t;

  state_t          state, state_nx;
  logic [DIVW-1:0] div;
  logic [DW-1:0]   sr_tx, sr_rx, sr_tx_nx, sr_rx_nx;
  logic [CSW-1:0]  cs_q;
  logic            cpol_q, cpha_q, arm;
  logic            accept, ce_tact, last_edge, lead, trail, drive, sample, done;
  logic            rx_in, tx_bit;

`ifdef SPI_LOOPBACK_EN
  logic unused_miso;
  assign unused_miso = MISO;
  assign rx_in = MOSI;
`else
  assign rx_in = MISO;
`endif

  always_ff @(posedge clk) begin
    if (clr) state <= IDLE;
    else     state <= state_nx;
  end

  // arm marks the cycle between accepting st and asserting SS; busy is still low then
  always_comb begin
    state_nx  = state;
    ce_tact   = (state != IDLE) && (div == DIVW'(HALF_DIV - 1));
    last_edge = (cb_bit == 8'(2 * DW - 1));
    accept    = (state == IDLE) && !arm && !end_TX && st && (int'(cs_sel) < NCS);
    lead      = ce_tact && (state == ACTIVE) && !cb_bit[0];
    trail     = ce_tact && (state == ACTIVE) && cb_bit[0];
    drive     = (arm && !cpha_q) || (lead && cpha_q) || (trail && !cpha_q && !last_edge);
    sample    = (lead && !cpha_q) || (trail && cpha_q);
    done      = ce_tact && (state == GUARD);
    case (state)
      IDLE:    if (arm) state_nx = ACTIVE;
      ACTIVE:  if (trail && last_edge) state_nx = GUARD;
      GUARD:   if (done) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    tx_bit   = 1'b0;
    sr_tx_nx = sr_tx;
    sr_rx_nx = sr_rx;
    if (MSB_FIRST != 0) begin
      tx_bit   = sr_tx[DW-1];
      sr_tx_nx = {sr_tx[DW-2:0], 1'b0};
      sr_rx_nx = {sr_rx[DW-2:0], rx_in};
    end else begin
      tx_bit   = sr_tx[0];
      sr_tx_nx = {1'b0, sr_tx[DW-1:1]};
      sr_rx_nx = {rx_in, sr_rx[DW-1:1]};
    end
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      SS_n   <= '1;
      SCLK   <= 1'b0;
      MOSI   <= 1'b0;
      rx_dat <= '0;
      busy   <= 1'b0;
      end_TX <= 1'b0;
      cb_bit <= '0;
      div    <= '0;
      sr_tx  <= '0;
      sr_rx  <= '0;
      cs_q   <= '0;
      cpol_q <= 1'b0;
      cpha_q <= 1'b0;
      arm    <= 1'b0;
    end else begin
      end_TX <= 1'b0;
      if (accept) begin
        sr_tx  <= tx_dat;
        sr_rx  <= '0;
        cs_q   <= cs_sel;
        cpol_q <= cpol;
        cpha_q <= cpha;
        div    <= '0;
        cb_bit <= '0;
        arm    <= 1'b1;
      end
      if (arm) begin
        arm  <= 1'b0;
        SS_n <= ~(NCS'(1) << cs_q);
        busy <= 1'b1;
        SCLK <= cpol_q;
      end
      if (state != IDLE) div <= ce_tact ? '0 : div + 1'b1;
      if (ce_tact && (state == ACTIVE)) begin
        SCLK   <= ~SCLK;
        cb_bit <= cb_bit + 8'd1;
      end
      if (drive) begin
        MOSI  <= tx_bit;
        sr_tx <= sr_tx_nx;
      end
      if (sample) sr_rx <= sr_rx_nx;
      if (done) begin
        SS_n   <= '1;
        busy   <= 1'b0;
        rx_dat <= sr_rx;
        end_TX <= 1'b1;
        MOSI   <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_spi_master_param.sv
// Bench for spi_master_param: default instance and a 16-bit LSB-first instance, each with a behavioural slave.
module tb_spi_master_param;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [1:0]       clr_r = 2'b11, st_r = '0, cpol_r = '0, cpha_r = '0;
  logic [1:0][1:0]  cs_r  = '0;
  logic [1:0][31:0] tx_r  = '0, slv_r = '0;
  wire  [1:0]       miso_w, mosi_w, sclk_w, busy_w, end_w;
  wire  [1:0][7:0]  ssn_w, cb_w;
  wire  [1:0][31:0] rx_w;
  int total = 0, bad = 0;

  spi_master_param u_a (
    .clk(clk), .clr(clr_r[0]), .st(st_r[0]), .cs_sel(cs_r[0][0:0]), .cpol(cpol_r[0]), .cpha(cpha_r[0]),
    .tx_dat(tx_r[0][10:0]), .MISO(miso_w[0]), .MOSI(mosi_w[0]), .SCLK(sclk_w[0]), .SS_n(ssn_w[0][1:0]),
    .rx_dat(rx_w[0][10:0]), .busy(busy_w[0]), .end_TX(end_w[0]), .cb_bit(cb_w[0])
  );
  assign ssn_w[0][7:2]  = '1;
  assign rx_w[0][31:11] = '0;

  spi_master_param #(.DW(16), .HALF_DIV(2), .NCS(3), .MSB_FIRST(0)) u_b (
    .clk(clk), .clr(clr_r[1]), .st(st_r[1]), .cs_sel(cs_r[1]), .cpol(cpol_r[1]), .cpha(cpha_r[1]),
    .tx_dat(tx_r[1][15:0]), .MISO(miso_w[1]), .MOSI(mosi_w[1]), .SCLK(sclk_w[1]), .SS_n(ssn_w[1][2:0]),
    .rx_dat(rx_w[1][15:0]), .busy(busy_w[1]), .end_TX(end_w[1]), .cb_bit(cb_w[1])
  );
  assign ssn_w[1][7:3]  = '1;
  assign rx_w[1][31:16] = '0;

  // Behavioural slave: follows SPI mode rules, counts edges and checks spacing and MOSI stability
  for (genvar g = 0; g < 2; g++) begin : slv
    localparam int DWG  = (g == 0) ? 11 : 16;
    localparam int HDG  = (g == 0) ? 25 : 2;
    localparam bit MSBG = (g == 0);
    logic in_fr = 1'b0, prev_sclk = 1'b0, prev_mosi = 1'b0, miso_l = 1'b0;
    logic [31:0] got = '0;
    int edges = 0, tcnt = 0, rbit = 0, wbit = 0, gap_bad = 0, mosi_bad = 0, falls = 0, first_bit = 0;
    function automatic int pos(input int n);
      return MSBG ? DWG - 1 - n : n;
    endfunction
    always @(negedge clk) begin
      logic lead, chg, smp;
      chg = 1'b0;
      if (!in_fr && ssn_w[g] != 8'hFF) begin
        in_fr = 1'b1; edges = 0; tcnt = 0; rbit = 0; wbit = 0; got = '0; falls++;
        if (!cpha_r[g]) begin
          miso_l = slv_r[g][pos(0)];
          wbit = 1;
        end
      end else if (in_fr && ssn_w[g] == 8'hFF) begin
        in_fr = 1'b0;
      end else if (in_fr) begin
        tcnt++;
        if (sclk_w[g] != prev_sclk) begin
          edges++;
          if (tcnt != HDG) gap_bad++;
          tcnt = 0;
          lead = edges[0];
          chg  = cpha_r[g] ? lead : (!lead && edges < 2 * DWG);
          smp  = cpha_r[g] ? !lead : lead;
          if (smp && rbit < DWG) begin
            if (rbit == 0) first_bit = int'(mosi_w[g]);
            got[pos(rbit)] = mosi_w[g];
            rbit++;
          end
          if (chg && wbit < DWG) begin
            miso_l = slv_r[g][pos(wbit)];
            wbit++;
          end
        end
        if (mosi_w[g] != prev_mosi && !chg) mosi_bad++;
      end
      prev_sclk = sclk_w[g];
      prev_mosi = mosi_w[g];
    end
    assign miso_w[g] = miso_l;
  end

  function automatic logic [31:0] got_of(input int i);     return (i == 0) ? slv[0].got : slv[1].got; endfunction
  function automatic int edges_of(input int i);            return (i == 0) ? slv[0].edges : slv[1].edges; endfunction
  function automatic int falls_of(input int i);            return (i == 0) ? slv[0].falls : slv[1].falls; endfunction
  function automatic int gaps_of(input int i);             return (i == 0) ? slv[0].gap_bad : slv[1].gap_bad; endfunction
  function automatic int mosib_of(input int i);            return (i == 0) ? slv[0].mosi_bad : slv[1].mosi_bad; endfunction
  function automatic int first_of(input int i);            return (i == 0) ? slv[0].first_bit : slv[1].first_bit; endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] expect_rx(input logic [31:0] txv, input logic [31:0] slvv);
`ifdef SPI_LOOPBACK_EN
    return txv;
`else
    return slvv;
`endif
  endfunction

  task automatic run_frame(input int i, input logic [31:0] txv_in, input logic [31:0] slvv_in,
                           input logic pol, input logic pha, input logic [1:0] cs, input string tag);
    int dw, hd, lat, n;
    logic [31:0] m, txv, slvv;
    dw   = (i == 0) ? 11 : 16;
    hd   = (i == 0) ? 25 : 2;
    lat  = 1 + (2 * dw + 1) * hd;
    m    = (32'd1 << dw) - 32'd1;
    txv  = txv_in & m;
    slvv = slvv_in & m;
    @(negedge clk);
    tx_r[i] = txv; slv_r[i] = slvv; cpol_r[i] = pol; cpha_r[i] = pha; cs_r[i] = cs; st_r[i] = 1'b1;
    @(negedge clk);
    st_r[i] = 1'b0;
    n = 0;
    @(negedge clk);
    n = 1;
    chk({tag, ".ss"}, {24'h0, ssn_w[i]}, {24'h0, ~(8'd1 << cs)});
    chk({tag, ".busy"}, {31'h0, busy_w[i]}, 32'd1);
    chk({tag, ".sclk_idle"}, {31'h0, sclk_w[i]}, {31'h0, pol});
    while (end_w[i] !== 1'b1 && n < lat + 20) begin
      @(negedge clk);
      n++;
    end
    chk({tag, ".lat"}, n, lat);
    chk({tag, ".rx"}, rx_w[i], expect_rx(txv, slvv));
    chk({tag, ".slave_rx"}, got_of(i), txv);
    chk({tag, ".edges"}, edges_of(i), 2 * dw);
    chk({tag, ".gap"}, gaps_of(i), 0);
    chk({tag, ".mosi_edge"}, mosib_of(i), 0);
    chk({tag, ".sclk_end"}, {31'h0, sclk_w[i]}, {31'h0, pol});
    chk({tag, ".ss_end"}, {24'h0, ssn_w[i]}, 32'hFF);
    chk({tag, ".busy_end"}, {31'h0, busy_w[i]}, 32'd0);
    @(negedge clk);
    chk({tag, ".pulse"}, {31'h0, end_w[i]}, 32'd0);
  endtask

  initial begin
    int f0, n, ends;
    logic [31:0] a, b;
    // reset, with st raised to confirm clr dominates
    st_r = 2'b11;
    repeat (3) @(negedge clk);
    clr_r = 2'b00;
    st_r  = 2'b00;
    for (int i = 0; i < 2; i++) begin
      chk("rst.ss", {24'h0, ssn_w[i]}, 32'hFF);
      chk("rst.sclk", {31'h0, sclk_w[i]}, 32'd0);
      chk("rst.mosi", {31'h0, mosi_w[i]}, 32'd0);
      chk("rst.rx", rx_w[i], 32'd0);
      chk("rst.busy", {31'h0, busy_w[i]}, 32'd0);
      chk("rst.end", {31'h0, end_w[i]}, 32'd0);
      chk("rst.cb", {24'h0, cb_w[i]}, 32'd0);
    end

    // the four modes with the reference frame
    for (int md = 0; md < 4; md++)
      run_frame(0, 32'b01100100100, 32'b10110001101, md[1], md[0], 2'd0, $sformatf("mode%0d", md));

    for (int k = 0; k < 4; k++)
      run_frame(0, $urandom, $urandom, 1'($urandom), 1'($urandom), 2'($urandom_range(1, 0)), $sformatf("rndA%0d", k));

    // st held through the whole frame and through the end_TX cycle
    f0 = falls_of(0);
    a  = $urandom & 32'h7FF;
    b  = $urandom & 32'h7FF;
    @(negedge clk);
    tx_r[0] = a; slv_r[0] = b; cpol_r[0] = 1'b0; cpha_r[0] = 1'b1; cs_r[0] = 2'd1; st_r[0] = 1'b1;
    n = 0;
    while (end_w[0] !== 1'b1 && n < 700) begin
      @(negedge clk);
      n++;
    end
    chk("held.end", {31'h0, end_w[0]}, 32'd1);
    chk("held.rx", rx_w[0], expect_rx(a, b));
    @(negedge clk);
    st_r[0] = 1'b0;
    repeat (5) @(negedge clk);
    chk("held.frames", falls_of(0), f0 + 1);
    chk("held.busy", {31'h0, busy_w[0]}, 32'd0);
    chk("held.ss", {24'h0, ssn_w[0]}, 32'hFF);

    // clr during a frame
    @(negedge clk);
    tx_r[0] = 32'h155; slv_r[0] = 32'h2AA; cpol_r[0] = 1'b1; cpha_r[0] = 1'b1; cs_r[0] = 2'd0; st_r[0] = 1'b1;
    @(negedge clk);
    st_r[0] = 1'b0;
    repeat (299) @(negedge clk);
    clr_r[0] = 1'b1;
    @(negedge clk);
    clr_r[0] = 1'b0;
    chk("clr.ss", {24'h0, ssn_w[0]}, 32'hFF);
    chk("clr.sclk", {31'h0, sclk_w[0]}, 32'd0);
    chk("clr.busy", {31'h0, busy_w[0]}, 32'd0);
    chk("clr.rx", rx_w[0], 32'd0);
    chk("clr.mosi", {31'h0, mosi_w[0]}, 32'd0);
    ends = 0;
    repeat (600) begin
      @(negedge clk);
      if (end_w[0] === 1'b1) ends++;
    end
    chk("clr.no_end", ends, 0);
    run_frame(0, 32'h3C5, 32'h1A6, 1'b0, 1'b0, 2'd1, "after_clr");

    // 16-bit LSB-first instance
    run_frame(1, 32'hA5C3, 32'h1234, 1'b0, 1'b0, 2'd0, "w16");
    chk("w16.first_bit", first_of(1), 1);
    f0 = falls_of(1);
    @(negedge clk);
    cs_r[1] = 2'd3; st_r[1] = 1'b1;
    @(negedge clk);
    st_r[1] = 1'b0;
    repeat (8) @(negedge clk);
    chk("badcs.busy", {31'h0, busy_w[1]}, 32'd0);
    chk("badcs.ss", {24'h0, ssn_w[1]}, 32'hFF);
    chk("badcs.frames", falls_of(1), f0);
    for (int k = 0; k < 4; k++)
      run_frame(1, $urandom, $urandom, 1'($urandom), 1'($urandom), 2'($urandom_range(2, 0)), $sformatf("rndB%0d", k));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
